pcie_cfg_cpl_decoder: RTL
=========================

# pcie_cfg_cpl_decoder

Receive-side counterpart of the configuration TLP encoder. Sinks the PCIe core's Requester Completion (RC) AXI4-Stream, matches each completion against the single outstanding CfgRd0/CfgWr0 request, and returns data and status to the configuration controller. It also flags stray completions and times out requests that are never answered.

## Interface
Parameters:
- C_DATA_WIDTH, 128, RC data width; only 128 is supported.
- KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width.
- AXI4_RC_TUSER_WIDTH, 75, RC tuser width.
- REQUESTER_ID, 16'h00AF, ID the encoder places in outgoing config requests.
- EXPECTED_TAG, 8'h00, tag used by config requests.
- TIMEOUT_CYCLES, 20'd500000, user_clk cycles to wait before declaring a timeout; must be ≥ 2.

Ports:
- user_clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- rc_tdata  in  C_DATA_WIDTH  completion beat.
- rc_tkeep  in  KEEP_WIDTH  ignored.
- rc_tuser  in  AXI4_RC_TUSER_WIDTH  ignored.
- rc_tlast  in  1  last beat of the TLP.
- rc_tvalid  in  1  beat valid.
- rc_tready  out  1  sink ready; registered.
- cpl_expect  in  1  one-cycle pulse that arms a wait; driven by the encoder's pkt_done.
- cpl_is_read  in  1  sampled on arm; 1 = CfgRd, so data is captured.
- cpl_func_num  in  2  sampled on arm; expected completer function.
- busy  out  1  a completion is being awaited.
- cpl_done  out  1  one-cycle pulse: result valid.
- cpl_data  out  32  read data; 0 for writes and timeouts.
- cpl_status  out  3  completion status field.
- cpl_ok  out  1  status==0, error code==0, not poisoned, no timeout.
- cpl_timeout  out  1  result was a timeout.
- cpl_unexpected  out  1  one-cycle pulse: a non-matching completion was dropped.

## Operation
- **Reset values:** rc_tready=0, busy=0, cpl_done=0, cpl_unexpected=0, cpl_data=0, cpl_status=0, cpl_ok=0, cpl_timeout=0. State=ST_IDLE, in_pkt=0, counter=0.
- **Ready:** rc_tready goes to 1 the first cycle after reset deasserts and stays 1. There is no backpressure.
- **Beat accept:** a beat is accepted when tvalid&&tready. A flag, in_pkt, marks the start of a packet:
  - the beat is SOP when in_pkt=0;
  - an accepted beat with tlast=0 sets in_pkt;
  - an accepted beat with tlast=1 clears in_pkt.
- **Decode:** only SOP beats are decoded; continuation beats are discarded. Fields:
  - error code [15:12]
  - dword count [42:32]
  - status [45:43]
  - poisoned [46]
  - requester ID [63:48]
  - tag [71:64]
  - completer function [74:72]
  - data DW [127:96]
- **States:**
  - ST_IDLE: on cpl_expect, latch cpl_is_read and cpl_func_num, clear the counter, and go to ST_WAIT. A SOP beat arriving in this state pulses cpl_unexpected.
  - ST_WAIT: busy=1.
    - **Match:** SOP && tag==EXPECTED_TAG && requester ID==REQUESTER_ID && function=={1'b0,func}. On match, register the result and go to ST_IDLE:
      - cpl_status=status;
      - cpl_data = (is_read && dword count==1 && status==0) ? DW3 : 0;
      - cpl_ok as defined in the Interface;
      - cpl_timeout=0;
      - cpl_done=1.
    - **Non-match SOP:** pulse cpl_unexpected and stay in ST_WAIT.
    - **Timeout:** the counter increments every ST_WAIT cycle without a match. When the counter reaches TIMEOUT_CYCLES-1, go to ST_IDLE with cpl_done=1, cpl_timeout=1, cpl_ok=0, cpl_status=0, cpl_data=0.
- **Result holding:** result outputs hold until the next cpl_done; only cpl_done and cpl_unexpected are pulses.
- **Boundary cases:**
  - Match and timeout in the same cycle: the match wins.
  - cpl_expect while in ST_WAIT: ignored; the latched context and counter are kept.
  - cpl_expect in the same cycle as a SOP beat in ST_IDLE: the beat counts as unexpected; arming takes effect next cycle.
  - A matching SOP with tlast=0: the result is reported from the SOP beat; the remaining beats are discarded.
  - Reset mid-packet: in_pkt clears, so the first beat accepted after reset is treated as SOP.

## Timing
- cpl_expect at cycle N → busy=1 at N+1. The counter is 0 at N+1.
- Matching beat accepted at cycle M → cpl_done, result outputs, and busy=0 at M+1.
- Timeout: with no match, cpl_done/cpl_timeout rise TIMEOUT_CYCLES cycles after busy rises.
- cpl_unexpected: rises one cycle after the offending SOP is accepted; one cycle wide.
- Back-to-back: a new cpl_expect is accepted in the same cycle cpl_done is high (state is already ST_IDLE).

## Test plan
- **Read completion:** arm with is_read=1, func=0; send one beat with tlast=1, tag 00, req ID 00AF, fn 0, status 0, dword count 1, DW3=32'hDEADBEEF → one cycle later cpl_done=1, cpl_data=DEADBEEF, cpl_ok=1, busy=0.
- **Write completion with error:** arm with is_read=0; send matching beat with status 3'b001 (UR) → cpl_done=1, cpl_status=1, cpl_ok=0, cpl_data=0.
- **Stray then good:** arm; send tag 05 → cpl_unexpected pulses and busy stays 1; then send tag 00 → cpl_done=1. Separately, a completion in ST_IDLE → cpl_unexpected only.
- **Timeout:** TIMEOUT_CYCLES=16; arm and send nothing → cpl_done with cpl_timeout=1 exactly 16 cycles after busy rises; a match landing on the final cycle → cpl_timeout=0.
- **Multi-beat and reset:** send a 2-beat non-matching TLP whose second beat resembles a match → no cpl_done. Assert reset after the first beat of a packet → all outputs return to reset values, rc_tready=0 during reset and 1 in the cycle after.

Source files
------------

// File: rtl/pcie_cfg_cpl_decoder.sv
// Requester Completion sink for configuration requests: matches each completion
// against the single outstanding CfgRd0/CfgWr0 and reports data, status and timeouts.
module pcie_cfg_cpl_decoder #(
    parameter int          C_DATA_WIDTH        = 128,
    parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int          AXI4_RC_TUSER_WIDTH = 75,
    parameter logic [15:0] REQUESTER_ID        = 16'h00AF,
    parameter logic [7:0]  EXPECTED_TAG        = 8'h00,
    parameter logic [19:0] TIMEOUT_CYCLES      = 20'd500000
) (
    input  logic                           user_clk,
    input  logic                           reset,
    input  logic [C_DATA_WIDTH-1:0]        rc_tdata,
    input  logic [KEEP_WIDTH-1:0]          rc_tkeep,
    input  logic [AXI4_RC_TUSER_WIDTH-1:0] rc_tuser,
    input  logic                           rc_tlast,
    input  logic                           rc_tvalid,
    output logic                           rc_tready,
    input  logic                           cpl_expect,
    input  logic                           cpl_is_read,
    input  logic [1:0]                     cpl_func_num,
    output logic                           busy,
    output logic                           cpl_done,
    output logic [31:0]                    cpl_data,
    output logic [2:0]                     cpl_status,
    output logic                           cpl_ok,
    output logic                           cpl_timeout,
    output logic                           cpl_unexpected
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        rc_tready_q, rc_tready_d;
    logic        in_pkt_q, in_pkt_d;
    logic [19:0] cnt_q, cnt_d;
    logic        is_read_q, is_read_d;
    logic [1:0]  func_q, func_d;
    logic        cpl_done_q, cpl_done_d;
    logic [31:0] cpl_data_q, cpl_data_d;
    logic [2:0]  cpl_status_q, cpl_status_d;
    logic        cpl_ok_q, cpl_ok_d;
    logic        cpl_timeout_q, cpl_timeout_d;
    logic        cpl_unexpected_q, cpl_unexpected_d;

    // Completion descriptor fields of the first beat.
    logic [3:0]  f_err_code;
    logic [10:0] f_dword_count;
    logic [2:0]  f_status;
    logic        f_poisoned;
    logic [15:0] f_requester_id;
    logic [7:0]  f_tag;
    logic [2:0]  f_function;
    logic [31:0] f_data;

    assign f_err_code     = rc_tdata[15:12];
    assign f_dword_count  = rc_tdata[42:32];
    assign f_status       = rc_tdata[45:43];
    assign f_poisoned     = rc_tdata[46];
    assign f_requester_id = rc_tdata[63:48];
    assign f_tag          = rc_tdata[71:64];
    assign f_function     = rc_tdata[74:72];
    assign f_data         = rc_tdata[127:96];

    logic beat_accept;
    logic sop;
    logic match;

    assign beat_accept = rc_tvalid && rc_tready_q;
    assign sop         = beat_accept && !in_pkt_q;
    assign match       = sop
                      && (f_tag == EXPECTED_TAG)
                      && (f_requester_id == REQUESTER_ID)
                      && (f_function == {1'b0, func_q});

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d          = state_q;
        rc_tready_d      = 1'b1;
        in_pkt_d         = in_pkt_q;
        cnt_d            = cnt_q;
        is_read_d        = is_read_q;
        func_d           = func_q;
        cpl_done_d       = 1'b0;
        cpl_data_d       = cpl_data_q;
        cpl_status_d     = cpl_status_q;
        cpl_ok_d         = cpl_ok_q;
        cpl_timeout_d    = cpl_timeout_q;
        cpl_unexpected_d = 1'b0;

        if (beat_accept) begin
            in_pkt_d = !rc_tlast;
        end

        unique case (state_q)
            ST_IDLE: begin
                // Any completion while nothing is outstanding is stray, even if arming now.
                if (sop) begin
                    cpl_unexpected_d = 1'b1;
                end
                if (cpl_expect) begin
                    is_read_d = cpl_is_read;
                    func_d    = cpl_func_num;
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (match) begin
                    cpl_status_d  = f_status;
                    cpl_data_d    = (is_read_q && (f_dword_count == 11'd1) && (f_status == 3'd0))
                                    ? f_data : 32'd0;
                    cpl_ok_d      = (f_status == 3'd0) && (f_err_code == 4'd0) && !f_poisoned;
                    cpl_timeout_d = 1'b0;
                    cpl_done_d    = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    if (sop) begin
                        cpl_unexpected_d = 1'b1;
                    end
                    // A match on the last counted cycle takes priority over the timeout.
                    if (cnt_q == TIMEOUT_CYCLES - 20'd1) begin
                        cpl_status_d  = 3'd0;
                        cpl_data_d    = 32'd0;
                        cpl_ok_d      = 1'b0;
                        cpl_timeout_d = 1'b1;
                        cpl_done_d    = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            rc_tready_q      <= 1'b0;
            in_pkt_q         <= 1'b0;
            cnt_q            <= '0;
            is_read_q        <= 1'b0;
            func_q           <= '0;
            cpl_done_q       <= 1'b0;
            cpl_data_q       <= '0;
            cpl_status_q     <= '0;
            cpl_ok_q         <= 1'b0;
            cpl_timeout_q    <= 1'b0;
            cpl_unexpected_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            rc_tready_q      <= rc_tready_d;
            in_pkt_q         <= in_pkt_d;
            cnt_q            <= cnt_d;
            is_read_q        <= is_read_d;
            func_q           <= func_d;
            cpl_done_q       <= cpl_done_d;
            cpl_data_q       <= cpl_data_d;
            cpl_status_q     <= cpl_status_d;
            cpl_ok_q         <= cpl_ok_d;
            cpl_timeout_q    <= cpl_timeout_d;
            cpl_unexpected_q <= cpl_unexpected_d;
        end
    end

    assign rc_tready      = rc_tready_q;
    assign busy           = (state_q == ST_WAIT);
    assign cpl_done       = cpl_done_q;
    assign cpl_data       = cpl_data_q;
    assign cpl_status     = cpl_status_q;
    assign cpl_ok         = cpl_ok_q;
    assign cpl_timeout    = cpl_timeout_q;
    assign cpl_unexpected = cpl_unexpected_q;

    // Sideband and descriptor bits the decoder does not look at.
    logic unused_bits;
    assign unused_bits = ^{rc_tkeep, rc_tuser, rc_tdata[11:0], rc_tdata[31:16],
                           rc_tdata[47], rc_tdata[95:75]};

endmodule
